dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
- Two-requester arbiter and sequencer in front of the single-port 32x32 data memory: port A (CPU load/store unit), port B (DMA/debug loader).
- Requests are serialised and each granted one memory access cycle. The block drives the memory's write enable, address and data-in, and returns the memory's combinational read data to the winning requester with a one-cycle ack pulse.
- Sits between the requesters and the data memory; the memory itself is unchanged: combinational read, write committed on posedge clk while we is high.

Parameters:
- DATA_W, 32, data width of the memory and of both ports.
- ADDR_W, 5, word address width (32 words).
- FIXED_PRI, 0: 0 = round-robin arbitration; 1 = port A always wins ties.

Ports:
- clk  in  1  system clock, all state updates on rising edge
- clrn  in  1  asynchronous active-low reset
- a_req  in  1  port A request; held high until a_ack
- a_we  in  1  port A write (1) / read (0); valid with a_req
- a_addr  in  ADDR_W  port A word address
- a_wdata  in  DATA_W  port A write data
- a_ack  out  1  port A one-cycle completion pulse
- a_rdata  out  DATA_W  port A read data; valid from a_ack, held until the next port A read completes
- b_req, b_we, b_addr, b_wdata, b_ack, b_rdata: same as the port A signals, for port B
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_W  memory address
- mem_din  out  DATA_W  memory write data
- mem_dout  in  DATA_W  memory combinational read data
- busy  out  1  high whenever state is not IDLE

Behaviour:
- Reset (clrn=0, asynchronous, immediate):
  - state=IDLE; mem_we, mem_addr, mem_din = 0.
  - a_ack, b_ack = 0; a_rdata, b_rdata = 0; busy = 0.
  - last_grant = B, so A wins the first tie.
- FSM states: IDLE, ACCESS, DONE.
- IDLE:
  - No req: stay in IDLE.
  - Any req: choose a winner, latch its we/addr/wdata into internal regs, record the winner, go to ACCESS.
  - Winner choice: only one req high → that port. Both high with FIXED_PRI=1 → A. Both high with FIXED_PRI=0 → the port not equal to last_grant.
- ACCESS (exactly one cycle):
  - mem_addr = latched addr; mem_din = latched wdata; mem_we = latched we.
  - The memory write commits at the rising edge that ends ACCESS.
  - For a read, mem_dout is captured into the winner's rdata register at that same edge.
  - Next state: DONE.
- DONE (one cycle):
  - Winner's ack = 1; mem_we = 0; last_grant updated to the winner.
  - Next state: IDLE.
- Timing and throughput:
  - Latency from a req sampled in IDLE to ack = 2 cycles (ack high in the 3rd cycle).
  - Throughput is at most one access per 3 cycles.
- mem_addr and mem_din hold their last value outside ACCESS. mem_we is high only during ACCESS with latched we=1.
- Requests and ack:
  - Requests are sampled only in IDLE. Changes to req/we/addr/wdata during ACCESS or DONE are ignored; the latched values are used.
  - A req still high in IDLE after its ack starts a new transaction. A requester wanting one access must drop req in the cycle after ack.
  - In round-robin mode, back-to-back requesters alternate strictly (A,B,A,B...). In fixed mode, a continuously requesting A starves B; this is intentional.
- A write leaves that port's rdata unchanged. The loser's rdata and ack are never disturbed.
- Reset during ACCESS:
  - mem_we drops immediately; the pending write is not committed.
  - No ack is issued; the transaction is lost and the requester must re-request.
- Both ack outputs are never high in the same cycle. At most one memory access is in flight.

Test Plan:
- Reset check: hold clrn=0 for 2 cycles → all outputs 0, busy=0. Release with no req → state stays IDLE, mem_we never rises.
- A single write then read:
  - A writes addr 3 = 0xDEADBEEF → mem_we high for exactly 1 cycle, a_ack 2 cycles after req is sampled.
  - A then reads addr 3 → a_rdata = 0xDEADBEEF when a_ack pulses.
- Preload read: B reads addr 10 on a memory initialised with ram[i]=i for i<11 → b_rdata = 0x0000000A, a_ack stays 0 throughout.
- Round-robin (FIXED_PRI=0): A and B both hold req for 4 transactions → grant order A,B,A,B; acks spaced 3 cycles apart; never simultaneous.
- Fixed priority (FIXED_PRI=1): both hold req → A served every transaction, b_ack never pulses. Drop a_req → B is served on the next IDLE.
- Reset mid-access: A writes addr 5 = 0x12345678, clrn pulled low during ACCESS → mem_we falls immediately, no a_ack, and a later read of addr 5 returns the prior value 5.

Source files
------------

// File: rtl/dmem_arbiter_if.sv
// ============================================================================
// dmem_arbiter_if
// ----------------------------------------------------------------------------
// Purpose:
//   Bundles the two requester ports (A: CPU load/store unit, B: DMA/debug
//   loader), the single-port data memory connection and the busy flag of the
//   data-memory arbiter into one interface.
//
// Signals:
//   a_req / b_req       request, held high until the matching ack
//   a_we / b_we         1 = write, 0 = read; valid with req
//   a_addr / b_addr     word address (ADDR_W bits)
//   a_wdata / b_wdata   write data (DATA_W bits)
//   a_ack / b_ack       one-cycle completion pulse
//   a_rdata / b_rdata   read data, held until the next read on that port
//   mem_we              memory write enable
//   mem_addr            memory address
//   mem_din             memory write data
//   mem_dout            memory combinational read data
//   busy                arbiter is not idle
//
// Modports:
//   slave  - the arbiter side
//   master - the requesters plus the memory (the environment around the arbiter)
// ============================================================================
interface dmem_arbiter_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);

    logic              a_req;
    logic              a_we;
    logic [ADDR_W-1:0] a_addr;
    logic [DATA_W-1:0] a_wdata;
    logic              a_ack;
    logic [DATA_W-1:0] a_rdata;

    logic              b_req;
    logic              b_we;
    logic [ADDR_W-1:0] b_addr;
    logic [DATA_W-1:0] b_wdata;
    logic              b_ack;
    logic [DATA_W-1:0] b_rdata;

    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_din;
    logic [DATA_W-1:0] mem_dout;

    logic              busy;

    modport slave (
        input  a_req, a_we, a_addr, a_wdata,
        output a_ack, a_rdata,
        input  b_req, b_we, b_addr, b_wdata,
        output b_ack, b_rdata,
        output mem_we, mem_addr, mem_din,
        input  mem_dout,
        output busy
    );

    modport master (
        output a_req, a_we, a_addr, a_wdata,
        input  a_ack, a_rdata,
        output b_req, b_we, b_addr, b_wdata,
        input  b_ack, b_rdata,
        input  mem_we, mem_addr, mem_din,
        output mem_dout,
        input  busy
    );

endinterface

// File: rtl/dmem_arbiter.sv
// ============================================================================
// dmem_arbiter
// ----------------------------------------------------------------------------
// Purpose:
//   Two-requester arbiter and sequencer in front of a single-port data memory
//   with combinational read and write-on-rising-edge. Each granted request
//   gets exactly one memory access cycle:
//
//     IDLE   -> pick a winner, latch its we/addr/wdata      (1 cycle min)
//     ACCESS -> memory sees latched addr/din/we; read data   (1 cycle)
//               and write both resolve at the closing edge
//     DONE   -> winner's ack is high for this one cycle      (1 cycle)
//
//   Latency from a request sampled in IDLE to ack is 2 cycles; throughput is
//   at most one access every 3 cycles.
//
// Parameters:
//   DATA_W     data width of the memory and both ports
//   ADDR_W     word address width
//   FIXED_PRI  0 = round-robin between A and B, 1 = A wins every tie
//
// Ports:
//   clk    system clock, rising-edge
//   clrn   asynchronous active-low reset
//   bus    dmem_arbiter_if.slave: requester ports A/B, memory port, busy
// ============================================================================
module dmem_arbiter #(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 5,
    parameter int FIXED_PRI = 0
) (
    input  logic           clk,
    input  logic           clrn,
    dmem_arbiter_if.slave  bus
);

    localparam bit L_FIXED = (FIXED_PRI != 0);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;

    // Transaction registers. r_mem_addr / r_mem_din drive the memory directly
    // so they naturally hold their last value outside ACCESS.
    logic              r_win_b;       // 1 = current transaction belongs to B
    logic              r_we;          // latched write flag of the winner
    logic              r_mem_we;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_din;

    logic              r_last_b;      // 1 = B was granted last
    logic              r_a_ack;
    logic              r_b_ack;
    logic [DATA_W-1:0] r_a_rdata;
    logic [DATA_W-1:0] r_b_rdata;

    logic              w_pick_b;      // winner if a transaction starts now
    logic              w_load;        // start a transaction at this edge
    logic              w_capture;     // close the access at this edge

    // ------------------------------------------------------------------------
    // Winner selection (only consumed in IDLE)
    // A wins when it is the only requester, or on a tie when priority is fixed
    // or when B had the previous grant.
    // ------------------------------------------------------------------------
    always_comb begin
        w_pick_b = 1'b0;
        if (bus.b_req) begin
            if (!bus.a_req) begin
                w_pick_b = 1'b1;
            end else if (!L_FIXED && !r_last_b) begin
                w_pick_b = 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // FSM next state and control strobes
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_capture   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.a_req || bus.b_req) begin
                    w_load      = 1'b1;
                    w_state_nxt = S_ACCESS;
                end
            end
            S_ACCESS: begin
                w_capture   = 1'b1;
                w_state_nxt = S_DONE;
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Datapath and handshake registers
    // The async reset clears mem_we at once, so a write pending in ACCESS is
    // never committed and no ack is produced for it.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            r_win_b    <= 1'b0;
            r_we       <= 1'b0;
            r_mem_we   <= 1'b0;
            r_mem_addr <= '0;
            r_mem_din  <= '0;
            r_last_b   <= 1'b1;
            r_a_ack    <= 1'b0;
            r_b_ack    <= 1'b0;
            r_a_rdata  <= '0;
            r_b_rdata  <= '0;
        end else begin
            // Single-cycle pulses default low.
            r_a_ack  <= 1'b0;
            r_b_ack  <= 1'b0;
            r_mem_we <= 1'b0;

            if (w_load) begin
                r_win_b <= w_pick_b;
                if (w_pick_b) begin
                    r_we       <= bus.b_we;
                    r_mem_we   <= bus.b_we;
                    r_mem_addr <= bus.b_addr;
                    r_mem_din  <= bus.b_wdata;
                end else begin
                    r_we       <= bus.a_we;
                    r_mem_we   <= bus.a_we;
                    r_mem_addr <= bus.a_addr;
                    r_mem_din  <= bus.a_wdata;
                end
            end

            // End of ACCESS: the memory commits a write at this same edge;
            // for a read the combinational output is captured here.
            if (w_capture) begin
                if (r_win_b) begin
                    r_b_ack <= 1'b1;
                    if (!r_we) begin
                        r_b_rdata <= bus.mem_dout;
                    end
                end else begin
                    r_a_ack <= 1'b1;
                    if (!r_we) begin
                        r_a_rdata <= bus.mem_dout;
                    end
                end
            end

            if (r_state == S_DONE) begin
                r_last_b <= r_win_b;
            end
        end
    end

    assign bus.mem_we   = r_mem_we;
    assign bus.mem_addr = r_mem_addr;
    assign bus.mem_din  = r_mem_din;
    assign bus.a_ack    = r_a_ack;
    assign bus.b_ack    = r_b_ack;
    assign bus.a_rdata  = r_a_rdata;
    assign bus.b_rdata  = r_b_rdata;
    assign bus.busy     = (r_state != S_IDLE);

endmodule

// File: tb/tb_dmem_arbiter.sv
module tb_dmem_arbiter;

    localparam int DW = 32;
    localparam int AW = 5;

    logic clk;
    logic clrn;

    dmem_arbiter_if #(.DATA_W(DW), .ADDR_W(AW)) bus_rr ();
    dmem_arbiter_if #(.DATA_W(DW), .ADDR_W(AW)) bus_fx ();

    dmem_arbiter #(.DATA_W(DW), .ADDR_W(AW), .FIXED_PRI(0)) dut_rr (
        .clk (clk),
        .clrn(clrn),
        .bus (bus_rr)
    );

    dmem_arbiter #(.DATA_W(DW), .ADDR_W(AW), .FIXED_PRI(1)) dut_fx (
        .clk (clk),
        .clrn(clrn),
        .bus (bus_fx)
    );

    // Behavioural data memories: combinational read, write on rising edge.
    logic [DW-1:0] ram_rr [32];
    logic [DW-1:0] ram_fx [32];

    initial begin
        for (int i = 0; i < 32; i++) begin
            ram_rr[i] = i;
            ram_fx[i] = i;
        end
    end

    always @(posedge clk) begin
        if (bus_rr.mem_we) ram_rr[bus_rr.mem_addr] <= bus_rr.mem_din;
        if (bus_fx.mem_we) ram_fx[bus_fx.mem_addr] <= bus_fx.mem_din;
    end

    assign bus_rr.mem_dout = ram_rr[bus_rr.mem_addr];
    assign bus_fx.mem_dout = ram_fx[bus_fx.mem_addr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic          a_req;
        logic          a_we;
        logic [AW-1:0] a_addr;
        logic [DW-1:0] a_wdata;
        logic          b_req;
        logic          b_we;
        logic [AW-1:0] b_addr;
        logic [DW-1:0] b_wdata;
        logic          e_busy;
        logic          e_we;
        logic [AW-1:0] e_addr;
        logic [DW-1:0] e_din;
        logic          e_aack;
        logic          e_back;
        logic [DW-1:0] e_ard;
        logic [DW-1:0] e_brd;
    } vec_t;

    function automatic vec_t mk(
        input logic ar, input logic aw, input logic [AW-1:0] aa, input logic [DW-1:0] ad,
        input logic br, input logic bw, input logic [AW-1:0] ba, input logic [DW-1:0] bd,
        input logic ebusy, input logic ewe, input logic [AW-1:0] eaddr, input logic [DW-1:0] edin,
        input logic eaack, input logic eback, input logic [DW-1:0] eard, input logic [DW-1:0] ebrd);
        vec_t v;
        v.a_req = ar;  v.a_we = aw;  v.a_addr = aa;  v.a_wdata = ad;
        v.b_req = br;  v.b_we = bw;  v.b_addr = ba;  v.b_wdata = bd;
        v.e_busy = ebusy; v.e_we = ewe; v.e_addr = eaddr; v.e_din = edin;
        v.e_aack = eaack; v.e_back = eback; v.e_ard = eard; v.e_brd = ebrd;
        return v;
    endfunction

    localparam int NV = 21;
    vec_t vt [NV];

    // Watchdog so the run always ends.
    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : main
        int  acks_a;
        int  acks_b;
        int  both;
        int  seen_we;
        int  seen_busy;
        int  lat;
        logic got;
        logic [DW-1:0] rd;

        // Each record: inputs applied on a falling edge, outputs expected on
        // the following falling edge (i.e. after one rising edge).
        //          A: req we addr data          B: req we addr data   exp: busy we addr din          aack back a_rdata       b_rdata
        vt[0]  = mk(1,1,3,32'hDEADBEEF, 0,0,0,0,  1,1,3,32'hDEADBEEF, 0,0,32'h0,        32'h0);
        vt[1]  = mk(1,1,3,32'hDEADBEEF, 0,0,0,0,  1,0,3,32'hDEADBEEF, 1,0,32'h0,        32'h0);
        vt[2]  = mk(0,1,3,32'hDEADBEEF, 0,0,0,0,  0,0,3,32'hDEADBEEF, 0,0,32'h0,        32'h0);
        vt[3]  = mk(1,0,3,32'h11111111, 0,0,0,0,  1,0,3,32'h11111111, 0,0,32'h0,        32'h0);
        vt[4]  = mk(1,0,3,32'h11111111, 0,0,0,0,  1,0,3,32'h11111111, 1,0,32'hDEADBEEF, 32'h0);
        vt[5]  = mk(0,0,3,32'h11111111, 0,0,0,0,  0,0,3,32'h11111111, 0,0,32'hDEADBEEF, 32'h0);
        vt[6]  = mk(0,0,3,32'h11111111, 1,0,10,0, 1,0,10,32'h0,       0,0,32'hDEADBEEF, 32'h0);
        vt[7]  = mk(0,0,3,32'h11111111, 1,0,10,0, 1,0,10,32'h0,       0,1,32'hDEADBEEF, 32'hA);
        vt[8]  = mk(0,0,3,32'h11111111, 0,0,10,0, 0,0,10,32'h0,       0,0,32'hDEADBEEF, 32'hA);
        vt[9]  = mk(1,0,1,0,            1,0,2,0,  1,0,1,32'h0,        0,0,32'hDEADBEEF, 32'hA);
        vt[10] = mk(1,0,1,0,            1,0,2,0,  1,0,1,32'h0,        1,0,32'h1,        32'hA);
        vt[11] = mk(1,0,1,0,            1,0,2,0,  0,0,1,32'h0,        0,0,32'h1,        32'hA);
        vt[12] = mk(1,0,1,0,            1,0,2,0,  1,0,2,32'h0,        0,0,32'h1,        32'hA);
        vt[13] = mk(1,0,1,0,            1,0,2,0,  1,0,2,32'h0,        0,1,32'h1,        32'h2);
        vt[14] = mk(1,0,1,0,            1,0,2,0,  0,0,2,32'h0,        0,0,32'h1,        32'h2);
        vt[15] = mk(1,0,4,0,            1,0,2,0,  1,0,4,32'h0,        0,0,32'h1,        32'h2);
        vt[16] = mk(1,0,7,0,            1,0,2,0,  1,0,4,32'h0,        1,0,32'h4,        32'h2);
        vt[17] = mk(1,0,7,0,            1,0,2,0,  0,0,4,32'h0,        0,0,32'h4,        32'h2);
        vt[18] = mk(1,0,7,0,            1,0,6,0,  1,0,6,32'h0,        0,0,32'h4,        32'h2);
        vt[19] = mk(1,0,7,0,            1,0,6,0,  1,0,6,32'h0,        0,1,32'h4,        32'h6);
        vt[20] = mk(0,0,7,0,            0,0,6,0,  0,0,6,32'h0,        0,0,32'h4,        32'h6);

        // ---------------- reset ----------------
        clrn = 1'b0;
        bus_rr.a_req = 0; bus_rr.a_we = 0; bus_rr.a_addr = 0; bus_rr.a_wdata = 0;
        bus_rr.b_req = 0; bus_rr.b_we = 0; bus_rr.b_addr = 0; bus_rr.b_wdata = 0;
        bus_fx.a_req = 0; bus_fx.a_we = 0; bus_fx.a_addr = 0; bus_fx.a_wdata = 0;
        bus_fx.b_req = 0; bus_fx.b_we = 0; bus_fx.b_addr = 0; bus_fx.b_wdata = 0;
        repeat (2) @(negedge clk);
        chk("rst_busy",     bus_rr.busy,     0);
        chk("rst_mem_we",   bus_rr.mem_we,   0);
        chk("rst_mem_addr", bus_rr.mem_addr, 0);
        chk("rst_mem_din",  bus_rr.mem_din,  0);
        chk("rst_a_ack",    bus_rr.a_ack,    0);
        chk("rst_b_ack",    bus_rr.b_ack,    0);
        chk("rst_a_rdata",  bus_rr.a_rdata,  0);
        chk("rst_b_rdata",  bus_rr.b_rdata,  0);
        chk("rst_fx_busy",  bus_fx.busy,     0);
        chk("rst_fx_we",    bus_fx.mem_we,   0);

        clrn = 1'b1;
        seen_we = 0; seen_busy = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (bus_rr.mem_we) seen_we++;
            if (bus_rr.busy)   seen_busy++;
        end
        chk("idle_no_we",   seen_we,   0);
        chk("idle_no_busy", seen_busy, 0);

        // ---------------- table: write/read, preload read, round-robin ----------------
        for (int k = 0; k < NV; k++) begin
            bus_rr.a_req = vt[k].a_req; bus_rr.a_we = vt[k].a_we;
            bus_rr.a_addr = vt[k].a_addr; bus_rr.a_wdata = vt[k].a_wdata;
            bus_rr.b_req = vt[k].b_req; bus_rr.b_we = vt[k].b_we;
            bus_rr.b_addr = vt[k].b_addr; bus_rr.b_wdata = vt[k].b_wdata;
            @(negedge clk);
            chk($sformatf("v%0d_busy", k),     bus_rr.busy,     vt[k].e_busy);
            chk($sformatf("v%0d_mem_we", k),   bus_rr.mem_we,   vt[k].e_we);
            chk($sformatf("v%0d_mem_addr", k), bus_rr.mem_addr, vt[k].e_addr);
            chk($sformatf("v%0d_mem_din", k),  bus_rr.mem_din,  vt[k].e_din);
            chk($sformatf("v%0d_a_ack", k),    bus_rr.a_ack,    vt[k].e_aack);
            chk($sformatf("v%0d_b_ack", k),    bus_rr.b_ack,    vt[k].e_back);
            chk($sformatf("v%0d_a_rdata", k),  bus_rr.a_rdata,  vt[k].e_ard);
            chk($sformatf("v%0d_b_rdata", k),  bus_rr.b_rdata,  vt[k].e_brd);
        end

        // ---------------- fixed priority: A starves B, then B served ----------------
        bus_fx.a_req = 1; bus_fx.a_we = 0; bus_fx.a_addr = 1;
        bus_fx.b_req = 1; bus_fx.b_we = 0; bus_fx.b_addr = 2;
        acks_a = 0; acks_b = 0; both = 0;
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            if (bus_fx.a_ack) acks_a++;
            if (bus_fx.b_ack) acks_b++;
            if (bus_fx.a_ack && bus_fx.b_ack) both++;
        end
        chk("fx_a_acks",   acks_a, 3);
        chk("fx_b_acks",   acks_b, 0);
        chk("fx_both",     both,   0);
        chk("fx_a_rdata",  bus_fx.a_rdata, 1);
        chk("fx_idle",     bus_fx.busy, 0);

        bus_fx.a_req = 0;
        got = 0; lat = 0;
        for (int i = 0; i < 6 && !got; i++) begin
            @(negedge clk);
            lat++;
            if (bus_fx.a_ack) acks_a++;
            if (bus_fx.b_ack) got = 1;
        end
        bus_fx.b_req = 0;
        chk("fx_b_served",  got, 1);
        chk("fx_b_latency", lat, 2);
        chk("fx_b_rdata",   bus_fx.b_rdata, 2);
        chk("fx_no_extra_a", acks_a, 3);

        // ---------------- reset during ACCESS ----------------
        @(negedge clk);
        bus_rr.a_req = 1; bus_rr.a_we = 1; bus_rr.a_addr = 5; bus_rr.a_wdata = 32'h12345678;
        @(negedge clk);
        chk("mid_we_before", bus_rr.mem_we, 1);
        #2;
        clrn = 1'b0;
        bus_rr.a_req = 0;
        #1;
        chk("mid_we_dropped", bus_rr.mem_we,   0);
        chk("mid_busy",       bus_rr.busy,     0);
        chk("mid_mem_addr",   bus_rr.mem_addr, 0);
        @(negedge clk);
        clrn = 1'b1;
        acks_a = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (bus_rr.a_ack) acks_a++;
        end
        chk("mid_no_ack", acks_a, 0);

        bus_rr.a_we = 0; bus_rr.a_addr = 5; bus_rr.a_req = 1;
        got = 0; rd = '0;
        for (int i = 0; i < 6 && !got; i++) begin
            @(negedge clk);
            if (bus_rr.a_ack) begin
                got = 1;
                rd  = bus_rr.a_rdata;
            end
        end
        bus_rr.a_req = 0;
        chk("mid_read_ack",  got, 1);
        chk("mid_read_data", rd,  32'h5);

        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
